sqrt_iter_core: RTL and testbench

Sequential restoring square-root engine: the iteration stage of the half-precision `sqrt2` datapath.
- Upstream, the normalize stage presents an exponent-parity-adjusted integer radicand.
- This block develops the integer root one bit per clock, with remainder and sticky flag.
- Downstream, the pack stage consumes root and sticky for rounding and assembly into the 16-bit result.
- Special operands (NaN, ±Inf, ±0, negatives) are resolved before this block; it sees only non-negative integers.

---
 rtl/sqrt_iter_if.sv | 30 +++
 rtl/sqrt_iter_core.sv | 111 +++++++++++
 tb/tb_sqrt_iter_core.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/sqrt_iter_if.sv
// sqrt_iter_if: handshake and result bundle for the iterative square-root core.
//   start    : request, sampled on rising clock edge while the core is idle
//   radicand : 2*RW-bit unsigned operand, captured with an accepted start
//   busy     : iteration in progress
//   done     : one-cycle pulse, results valid from this cycle
//   root     : floor(sqrt(radicand))
//   rem      : radicand - root^2 (never exceeds 2*root)
//   sticky   : rem is non-zero
// master drives the request; slave is the core.
interface sqrt_iter_if #(
  parameter int RW = 12
);
  logic              start;
  logic [2*RW-1:0]   radicand;
  logic              busy;
  logic              done;
  logic [RW-1:0]     root;
  logic [RW:0]       rem;
  logic              sticky;

  modport master (
    output start, radicand,
    input  busy, done, root, rem, sticky
  );

  modport slave (
    input  start, radicand,
    output busy, done, root, rem, sticky
  );
endinterface

// File: rtl/sqrt_iter_core.sv
// sqrt_iter_core: restoring integer square root, one root bit per clock.
// Iteration stage of the half-precision sqrt datapath; sees only
// non-negative integer radicands (specials are resolved upstream).
// Ports:
//   clk_i : clock, all state on rising edge
//   rst_i : asynchronous active-high reset
//   bus   : sqrt_iter_if slave (start/radicand in; busy/done/root/rem/sticky out)
// Latency: start accepted at edge 0, done high after edge RW, so a new
// operation can be accepted every RW+1 clocks.
module sqrt_iter_core #(
  parameter int RW = 12
) (
  input  logic        clk_i,
  input  logic        rst_i,
  sqrt_iter_if.slave  bus
);

  localparam int CW = (RW > 1) ? $clog2(RW) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic            busy_q;
  logic            done_q;

  // Working registers, kept separate so the outputs hold during RUN.
  logic [2*RW-1:0] rad_q;
  logic [RW-1:0]   wroot_q;
  logic [RW+1:0]   wrem_q;

  // Output registers.
  logic [RW-1:0]   root_q;
  logic [RW:0]     rem_q;
  logic            sticky_q;

  // Next working root/remainder for one restoring step.
  logic [RW+3:0]   minuend;
  logic [RW+3:0]   subtrahend;
  logic [RW+1:0]   trial;
  logic [RW-1:0]   root_d;
  logic [RW+1:0]   rem_d;

  always_comb begin
    minuend    = {wrem_q, rad_q[2*RW-1 -: 2]};
    subtrahend = {2'b00, wroot_q, 2'b01};
    // Compare at full width; the difference itself always fits RW+2 bits
    // when non-negative because the remainder never exceeds 2*root.
    trial      = minuend[RW+1:0] - subtrahend[RW+1:0];
    if (minuend >= subtrahend) begin
      rem_d  = trial;
      root_d = {wroot_q[RW-2:0], 1'b1};
    end else begin
      rem_d  = minuend[RW+1:0];
      root_d = {wroot_q[RW-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      rad_q    <= '0;
      wroot_q  <= '0;
      wrem_q   <= '0;
      root_q   <= '0;
      rem_q    <= '0;
      sticky_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            rad_q   <= bus.radicand;
            wroot_q <= '0;
            wrem_q  <= '0;
            cnt_q   <= CW'(RW - 1);
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          rad_q   <= {rad_q[2*RW-3:0], 2'b00};
          wroot_q <= root_d;
          wrem_q  <= rem_d;
          if (cnt_q == '0) begin
            // rem_d <= 2*root < 2^(RW+1), so the low RW+1 bits are exact.
            root_q   <= root_d;
            rem_q    <= rem_d[RW:0];
            sticky_q <= |rem_d;
            done_q   <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= IDLE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.root   = root_q;
  assign bus.rem    = rem_q;
  assign bus.sticky = sticky_q;

endmodule

// File: tb/tb_sqrt_iter_core.sv
module tb_sqrt_iter_core;

  localparam int RW = 12;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  sqrt_iter_if #(.RW(RW)) bus ();

  sqrt_iter_core #(.RW(RW)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Result the bench expects the outputs to be holding.
  logic [RW-1:0] last_root   = '0;
  logic [RW:0]   last_rem    = '0;
  logic          last_sticky = 1'b0;

  typedef struct {
    logic [2*RW-1:0] rad;
    logic [RW-1:0]   root;
    logic [RW:0]     rem;
    logic            sticky;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: largest integer whose square does not exceed x.
  function automatic void model(input logic [2*RW-1:0] x, output logic [RW-1:0] r,
                                output logic [RW:0] m, output logic s);
    longint v;
    longint q;
    v = longint'(x);
    q = 0;
    for (longint k = 0; k < (longint'(1) << RW); k++)
      if (k * k <= v) q = k;
    r = RW'(q);
    m = (RW + 1)'(v - q * q);
    s = (v != q * q);
  endfunction

  // Called at a time away from the rising edge. Applies one operation,
  // checks latency, output hold during RUN and the final result.
  task automatic do_op(input string tag, input logic [2*RW-1:0] r,
                       input logic [RW-1:0] er, input logic [RW:0] em, input logic es);
    bit hold_ok;
    bus.start    = 1'b1;
    bus.radicand = r;
    @(posedge clk); #1;
    bus.start    = 1'b0;
    bus.radicand = 2*RW'($urandom);
    chk({tag, "_busy_after_start"}, {bus.busy, bus.done}, 2'b10);
    hold_ok = 1'b1;
    for (int i = 1; i <= RW; i++) begin
      @(posedge clk); #1;
      if (i < RW) begin
        if (bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.root !== last_root ||
            bus.rem !== last_rem || bus.sticky !== last_sticky)
          hold_ok = 1'b0;
      end
    end
    chk({tag, "_hold_during_run"}, 32'(hold_ok), 32'd1);
    chk({tag, "_done_latency"}, {bus.busy, bus.done}, 2'b01);
    chk({tag, "_root"}, 32'(bus.root), 32'(er));
    chk({tag, "_rem"}, 32'(bus.rem), 32'(em));
    chk({tag, "_sticky"}, 32'(bus.sticky), 32'(es));
    last_root   = er;
    last_rem    = em;
    last_sticky = es;
  endtask

  initial begin
    logic [2*RW-1:0] r;
    logic [RW-1:0]   er;
    logic [RW:0]     em;
    logic            es;
    bit              no_done;

    vecs[0] = '{24'h400000, 12'h800, 13'd0,    1'b0};
    vecs[1] = '{24'h800000, 12'hB50, 13'd1792, 1'b1};
    vecs[2] = '{24'hFFFFFF, 12'hFFF, 13'd8190, 1'b1};
    vecs[3] = '{24'h000000, 12'h000, 13'd0,    1'b0};
    vecs[4] = '{24'd1,      12'd1,   13'd0,    1'b0};
    vecs[5] = '{24'd2,      12'd1,   13'd1,    1'b1};
    vecs[6] = '{24'd15,     12'd3,   13'd6,    1'b1};
    vecs[7] = '{24'd16,     12'd4,   13'd0,    1'b0};
    vecs[8] = '{24'd99,     12'd9,   13'd18,   1'b1};
    vecs[9] = '{24'hFFE001, 12'hFFF, 13'd0,    1'b0};

    bus.start    = 1'b0;
    bus.radicand = '0;

    #1;
    chk("reset_state", {bus.busy, bus.done, bus.sticky, 12'(bus.root), 13'(bus.rem)}, '0);

    // Release reset and request in the same low phase: first edge after release accepts.
    @(negedge clk);
    rst = 1'b0;
    do_op("first_4e5", 24'h400000, 12'h800, 13'd0, 1'b0);
    @(posedge clk); #1;
    chk("done_one_cycle", {bus.busy, bus.done}, 2'b00);

    for (int i = 0; i < 10; i++)
      do_op($sformatf("vec%0d", i), vecs[i].rad, vecs[i].root, vecs[i].rem, vecs[i].sticky);

    // Busy start ignored, then start in the DONE cycle.
    do_op("pre_b2b", 24'h000000, 12'h000, 13'd0, 1'b0);
    bus.start = 1'b1; bus.radicand = 24'h400000;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    bus.start = 1'b1; bus.radicand = 24'hFFFFFF;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("busy_start_still_busy", {bus.busy, bus.done}, 2'b10);
    repeat (RW - 5) @(posedge clk);
    #1;
    chk("b2b_first_done", {bus.busy, bus.done}, 2'b01);
    chk("b2b_first_root", 32'(bus.root), 32'h800);
    chk("b2b_first_rem", 32'(bus.rem), 32'd0);
    last_root = 12'h800; last_rem = '0; last_sticky = 1'b0;
    do_op("b2b_second", 24'h800000, 12'hB50, 13'd1792, 1'b1);

    // Reset in the middle of a run.
    bus.start = 1'b1; bus.radicand = 24'h800000;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("async_reset_clears", {bus.busy, bus.done, bus.sticky, 12'(bus.root), 13'(bus.rem)}, '0);
    @(posedge clk); #2;
    rst = 1'b0;
    no_done = 1'b1;
    for (int i = 0; i < RW + 3; i++) begin
      @(posedge clk); #1;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) no_done = 1'b0;
    end
    chk("no_done_after_abort", 32'(no_done), 32'd1);
    last_root = '0; last_rem = '0; last_sticky = 1'b0;
    do_op("after_reset", 24'h400000, 12'h800, 13'd0, 1'b0);

    // Randomized operands against the arithmetic reference.
    for (int i = 0; i < 30; i++) begin
      r = 2*RW'($urandom);
      if (i % 5 == 0) r = 2*RW'($urandom_range(0, 300));
      model(r, er, em, es);
      do_op($sformatf("rand%0d", i), r, er, em, es);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
